// File: rtl/rv64_csr_pkg.sv
// Shared constants for the machine-mode CSR file and trap sequencer:
// CSR addresses, op encodings, field indices, WARL masks and interrupt causes.
package rv64_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIP_MSIP     = 3;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;

    localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;
    localparam logic [63:0] MSTATUS_MPP   = 64'h0000_0000_0000_1800;
    localparam logic [63:0] MIE_WMASK     = 64'h0000_0000_0000_0888;
    // RV64 (MXL=2) with I, M and A extensions.
    localparam logic [63:0] MISA_VALUE    = 64'h8000_0000_0000_1101;

    localparam logic [63:0] IRQ_CAUSE_MSI = 64'h8000_0000_0000_0003;
    localparam logic [63:0] IRQ_CAUSE_MTI = 64'h8000_0000_0000_0007;
    localparam logic [63:0] IRQ_CAUSE_MEI = 64'h8000_0000_0000_000b;

    // Inhibit bits exist for mcycle (0), minstret (2) and each implemented hpm counter.
    function automatic logic [63:0] inhibit_wmask(input int num_hpm);
        logic [63:0] m;
        m = 64'h5;
        for (int k = 0; k < num_hpm; k++) begin
            m[3+k] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/rv64_csr_trap_unit_if.sv
// CSR access and trap/mret bus between the execute/commit stage (master)
// and the CSR trap unit (slave).
interface rv64_csr_trap_unit_if #(
    parameter int XLEN = 64
);
    logic [11:0]     csr_addr_i;
    logic [1:0]      csr_op_i;
    logic [XLEN-1:0] csr_wdata_i;
    logic [XLEN-1:0] csr_rdata_o;
    logic            csr_illegal_o;
    logic            trap_valid_i;
    logic [XLEN-1:0] trap_cause_i;
    logic [XLEN-1:0] trap_epc_i;
    logic [XLEN-1:0] trap_tval_i;
    logic            mret_i;
    logic [XLEN-1:0] trap_vector_o;
    logic [XLEN-1:0] mepc_o;

    modport master (
        output csr_addr_i, csr_op_i, csr_wdata_i,
        output trap_valid_i, trap_cause_i, trap_epc_i, trap_tval_i, mret_i,
        input  csr_rdata_o, csr_illegal_o, trap_vector_o, mepc_o
    );

    modport slave (
        input  csr_addr_i, csr_op_i, csr_wdata_i,
        input  trap_valid_i, trap_cause_i, trap_epc_i, trap_tval_i, mret_i,
        output csr_rdata_o, csr_illegal_o, trap_vector_o, mepc_o
    );
endinterface

// File: rtl/rv64_csr_counter.sv
// Free-running performance counter; a CSR write takes precedence over the increment.
module rv64_csr_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] wdata,
    input  logic             inc,
    input  logic             inhibit,
    output logic [WIDTH-1:0] value
);
    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (wen) begin
            count_reg <= wdata;
        end else if (inc && !inhibit) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign value = count_reg;
endmodule

// File: rtl/rv64_csr_trap_unit.sv
// Machine-mode CSR file with atomic read-modify-write ops, trap entry / mret
// sequencing, interrupt pending logic and inhibitable performance counters.
module rv64_csr_trap_unit
    import rv64_csr_pkg::*;
#(
    parameter int          XLEN          = 64,
    parameter int          NUM_HPM       = 2,
    parameter logic [63:0] MSTATUS_RESET = 64'h0000_000a_0000_1800,
    parameter bit          VECTORED_EN   = 1'b1,
    localparam int         HPM_W         = (NUM_HPM > 0) ? NUM_HPM : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    rv64_csr_trap_unit_if.slave  bus,
    input  logic                 retire_i,
    input  logic [HPM_W-1:0]     hpm_event_i,
    input  logic                 irq_msip_i,
    input  logic                 irq_mtip_i,
    input  logic                 irq_meip_i,
    output logic                 irq_pending_o,
    output logic [XLEN-1:0]      irq_cause_o
);
    localparam logic [63:0] INHIBIT_WMASK = inhibit_wmask(NUM_HPM);

    logic [63:0] mstatus_reg, mstatus_next;
    logic [63:0] mie_reg, mie_next;
    logic [63:0] mip_reg, mip_next;
    logic [63:0] mtvec_reg, mtvec_next;
    logic [63:0] mscratch_reg, mscratch_next;
    logic [63:0] mepc_reg, mepc_next;
    logic [63:0] mcause_reg, mcause_next;
    logic [63:0] mtval_reg, mtval_next;
    logic [63:0] mcountinhibit_reg, mcountinhibit_next;

    logic [63:0] mcycle_value, minstret_value;
    logic [63:0] hpm_value [HPM_W];

    csr_op_e     op;
    logic [63:0] old_value, new_value;
    logic        addr_valid, read_only, do_write, illegal, wr_ok;

    assign op = csr_op_e'(bus.csr_op_i);

    // Read mux; counters report their value before this cycle's increment.
    always_comb begin
        old_value  = '0;
        addr_valid = 1'b1;
        case (bus.csr_addr_i)
            CSR_MSTATUS:       old_value = mstatus_reg | MSTATUS_MPP;
            CSR_MISA:          old_value = MISA_VALUE;
            CSR_MHARTID:       old_value = '0;
            CSR_MIE:           old_value = mie_reg;
            CSR_MIP:           old_value = mip_reg;
            CSR_MTVEC:         old_value = mtvec_reg;
            CSR_MSCRATCH:      old_value = mscratch_reg;
            CSR_MEPC:          old_value = mepc_reg;
            CSR_MCAUSE:        old_value = mcause_reg;
            CSR_MTVAL:         old_value = mtval_reg;
            CSR_MCOUNTINHIBIT: old_value = mcountinhibit_reg;
            CSR_MCYCLE:        old_value = mcycle_value;
            CSR_MINSTRET:      old_value = minstret_value;
            default: begin
                addr_valid = 1'b0;
                for (int k = 0; k < NUM_HPM; k++) begin
                    if (bus.csr_addr_i == CSR_MHPMCOUNTER3 + 12'(k)) begin
                        addr_valid = 1'b1;
                        old_value  = hpm_value[k];
                    end
                end
            end
        endcase
    end

    always_comb begin
        new_value = old_value;
        case (op)
            CSR_OP_WRITE: new_value = bus.csr_wdata_i;
            CSR_OP_SET:   new_value = old_value | bus.csr_wdata_i;
            CSR_OP_CLEAR: new_value = old_value & ~bus.csr_wdata_i;
            default:      new_value = old_value;
        endcase
    end

    // Set/clear with a zero mask is a pure read, so it is legal even on read-only CSRs.
    assign do_write  = (op == CSR_OP_WRITE) ||
                       ((op == CSR_OP_SET || op == CSR_OP_CLEAR) && (bus.csr_wdata_i != '0));
    assign read_only = (bus.csr_addr_i == CSR_MISA) || (bus.csr_addr_i == CSR_MHARTID);
    assign illegal   = !addr_valid || (do_write && read_only);
    assign wr_ok     = do_write && !illegal;

    // Later assignments override earlier ones: CSR op < mret < trap.
    always_comb begin
        mstatus_next       = mstatus_reg;
        mie_next           = mie_reg;
        mtvec_next         = mtvec_reg;
        mscratch_next      = mscratch_reg;
        mepc_next          = mepc_reg;
        mcause_next        = mcause_reg;
        mtval_next         = mtval_reg;
        mcountinhibit_next = mcountinhibit_reg;
        if (wr_ok) begin
            case (bus.csr_addr_i)
                CSR_MSTATUS:  mstatus_next  = (mstatus_reg & ~MSTATUS_WMASK) | (new_value & MSTATUS_WMASK);
                CSR_MIE:      mie_next      = new_value & MIE_WMASK;
                CSR_MTVEC:    mtvec_next    = {new_value[63:2], 1'b0,
                                               (VECTORED_EN && (new_value[1:0] == 2'b01))};
                CSR_MSCRATCH: mscratch_next = new_value;
                CSR_MEPC:     mepc_next     = new_value & ~64'h3;
                CSR_MCAUSE:   mcause_next   = new_value;
                CSR_MTVAL:    mtval_next    = new_value;
                CSR_MCOUNTINHIBIT: mcountinhibit_next = new_value & INHIBIT_WMASK;
                default: ;
            endcase
        end
        if (bus.mret_i) begin
            mstatus_next[MSTATUS_MIE]  = mstatus_reg[MSTATUS_MPIE];
            mstatus_next[MSTATUS_MPIE] = 1'b1;
        end
        if (bus.trap_valid_i) begin
            mstatus_next[MSTATUS_MPIE] = mstatus_reg[MSTATUS_MIE];
            mstatus_next[MSTATUS_MIE]  = 1'b0;
            mepc_next                  = bus.trap_epc_i & ~64'h3;
            mcause_next                = bus.trap_cause_i;
            mtval_next                 = bus.trap_tval_i;
        end
        mstatus_next = mstatus_next | MSTATUS_MPP;
    end

    always_comb begin
        mip_next           = '0;
        mip_next[MIP_MSIP] = irq_msip_i;
        mip_next[MIP_MTIP] = irq_mtip_i;
        mip_next[MIP_MEIP] = irq_meip_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_reg       <= MSTATUS_RESET;
            mie_reg           <= '0;
            mip_reg           <= '0;
            mtvec_reg         <= '0;
            mscratch_reg      <= '0;
            mepc_reg          <= '0;
            mcause_reg        <= '0;
            mtval_reg         <= '0;
            mcountinhibit_reg <= '0;
        end else begin
            mstatus_reg       <= mstatus_next;
            mie_reg           <= mie_next;
            mip_reg           <= mip_next;
            mtvec_reg         <= mtvec_next;
            mscratch_reg      <= mscratch_next;
            mepc_reg          <= mepc_next;
            mcause_reg        <= mcause_next;
            mtval_reg         <= mtval_next;
            mcountinhibit_reg <= mcountinhibit_next;
        end
    end

    rv64_csr_counter #(.WIDTH(64)) u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .wen     (wr_ok && (bus.csr_addr_i == CSR_MCYCLE)),
        .wdata   (new_value),
        .inc     (1'b1),
        .inhibit (mcountinhibit_reg[0]),
        .value   (mcycle_value)
    );

    rv64_csr_counter #(.WIDTH(64)) u_minstret (
        .clk     (clk),
        .rst     (rst),
        .wen     (wr_ok && (bus.csr_addr_i == CSR_MINSTRET)),
        .wdata   (new_value),
        .inc     (retire_i),
        .inhibit (mcountinhibit_reg[2]),
        .value   (minstret_value)
    );

    generate
        for (genvar gi = 0; gi < NUM_HPM; gi++) begin : g_hpm
            rv64_csr_counter #(.WIDTH(64)) u_hpm (
                .clk     (clk),
                .rst     (rst),
                .wen     (wr_ok && (bus.csr_addr_i == CSR_MHPMCOUNTER3 + 12'(gi))),
                .wdata   (new_value),
                .inc     (hpm_event_i[gi]),
                .inhibit (mcountinhibit_reg[3+gi]),
                .value   (hpm_value[gi])
            );
        end
    endgenerate

    // Vectored mode only applies to asynchronous (interrupt) causes.
    logic [63:0] tvec_base;
    assign tvec_base = {mtvec_reg[63:2], 2'b00};
    assign bus.trap_vector_o = (mtvec_reg[1:0] == 2'b01 && bus.trap_cause_i[63])
                             ? tvec_base + {56'd0, bus.trap_cause_i[5:0], 2'b00}
                             : tvec_base;

    assign bus.csr_rdata_o   = old_value;
    assign bus.csr_illegal_o = illegal;
    assign bus.mepc_o        = mepc_reg;

    logic [63:0] irq_active;
    assign irq_active    = mie_reg & mip_reg;
    assign irq_pending_o = mstatus_reg[MSTATUS_MIE] && (|irq_active);

    always_comb begin
        irq_cause_o = '0;
        if (irq_pending_o) begin
            if (irq_active[MIP_MEIP])      irq_cause_o = IRQ_CAUSE_MEI;
            else if (irq_active[MIP_MSIP]) irq_cause_o = IRQ_CAUSE_MSI;
            else if (irq_active[MIP_MTIP]) irq_cause_o = IRQ_CAUSE_MTI;
        end
    end
endmodule

// File: tb/tb_rv64_csr_trap_unit.sv
// Directed bench for rv64_csr_trap_unit: CSR ops, WARL, trap/mret, vectoring,
// interrupt priority, counters and asynchronous reset.
module tb_rv64_csr_trap_unit;
    import rv64_csr_pkg::*;

    logic        clk;
    logic        rst;
    logic        retire;
    logic [1:0]  hpm_event;
    logic        msip, mtip, meip;
    logic        irq_pending;
    logic [63:0] irq_cause;
    logic [63:0] v;

    int checks   = 0;
    int failures = 0;

    rv64_csr_trap_unit_if #(.XLEN(64)) bus ();

    rv64_csr_trap_unit #(
        .XLEN          (64),
        .NUM_HPM       (2),
        .MSTATUS_RESET (64'h0000_000a_0000_1800),
        .VECTORED_EN   (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .retire_i      (retire),
        .hpm_event_i   (hpm_event),
        .irq_msip_i    (msip),
        .irq_mtip_i    (mtip),
        .irq_meip_i    (meip),
        .irq_pending_o (irq_pending),
        .irq_cause_o   (irq_cause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1ns later, and drop any CSR op.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.csr_op_i = CSR_OP_NONE;
    endtask

    task automatic csr(input logic [11:0] a, input logic [1:0] o, input logic [63:0] d);
        bus.csr_addr_i  = a;
        bus.csr_op_i    = o;
        bus.csr_wdata_i = d;
        #1;
    endtask

    task automatic rd(input logic [11:0] a, output logic [63:0] d);
        bus.csr_addr_i  = a;
        bus.csr_op_i    = CSR_OP_NONE;
        bus.csr_wdata_i = '0;
        #1;
        d = bus.csr_rdata_o;
    endtask

    initial begin
        rst = 1'b1;
        retire = 1'b0; hpm_event = 2'b00;
        msip = 1'b0; mtip = 1'b0; meip = 1'b0;
        bus.csr_addr_i = '0; bus.csr_op_i = CSR_OP_NONE; bus.csr_wdata_i = '0;
        bus.trap_valid_i = 1'b0; bus.trap_cause_i = '0; bus.trap_epc_i = '0;
        bus.trap_tval_i = '0; bus.mret_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        rd(CSR_MSTATUS, v);  chk("rst_mstatus", v, 64'h0000_000a_0000_1800);
        chk1("rst_illegal", bus.csr_illegal_o, 1'b0);
        rd(CSR_MISA, v);     chk("rst_misa", v, 64'h8000_0000_0000_1101);
        rd(CSR_MSCRATCH, v); chk("rst_mscratch", v, 64'h0);
        chk("rst_mepc_o", bus.mepc_o, 64'h0);
        chk("rst_trap_vector", bus.trap_vector_o, 64'h0);
        chk1("rst_irq_pending", irq_pending, 1'b0);
        chk("rst_irq_cause", irq_cause, 64'h0);

        // Back-to-back set/clear of MIE
        csr(CSR_MSTATUS, CSR_OP_SET, 64'h8);
        chk("set_old_value", bus.csr_rdata_o, 64'h0000_000a_0000_1800);
        tick();
        csr(CSR_MSTATUS, CSR_OP_CLEAR, 64'h8);
        chk("set_mie", bus.csr_rdata_o, 64'h0000_000a_0000_1808);
        tick();
        rd(CSR_MSTATUS, v); chk("clear_mie", v, 64'h0000_000a_0000_1800);
        csr(CSR_MSTATUS, CSR_OP_SET, 64'h0);
        chk1("set0_illegal", bus.csr_illegal_o, 1'b0);
        tick();
        rd(CSR_MSTATUS, v); chk("set0_nowrite", v, 64'h0000_000a_0000_1800);

        // Illegal accesses
        csr(CSR_MISA, CSR_OP_WRITE, 64'h0);
        chk1("misa_write_illegal", bus.csr_illegal_o, 1'b1);
        tick();
        rd(CSR_MISA, v); chk("misa_unchanged", v, 64'h8000_0000_0000_1101);
        rd(12'h7C0, v);  chk1("unimpl_illegal", bus.csr_illegal_o, 1'b1);
        rd(12'hB05, v);  chk1("hpm5_illegal", bus.csr_illegal_o, 1'b1);
        rd(CSR_MHARTID, v); chk("mhartid", v, 64'h0);
        chk1("mhartid_read_legal", bus.csr_illegal_o, 1'b0);

        // mstatus WARL
        csr(CSR_MSTATUS, CSR_OP_WRITE, 64'hFFFF_FFFF_FFFF_FFFF); tick();
        rd(CSR_MSTATUS, v); chk("mstatus_warl", v, 64'h0000_000a_0000_1888);
        csr(CSR_MSTATUS, CSR_OP_WRITE, 64'h8); tick();
        rd(CSR_MSTATUS, v); chk("mstatus_mpp_sticky", v, 64'h0000_000a_0000_1808);

        // Trap entry; a same-cycle CSR write to mepc must be dropped
        bus.trap_valid_i = 1'b1;
        bus.trap_cause_i = 64'h2;
        bus.trap_epc_i   = 64'h8000_0102;
        bus.trap_tval_i  = 64'hdead;
        csr(CSR_MEPC, CSR_OP_WRITE, 64'h1234);
        tick();
        bus.trap_valid_i = 1'b0;
        chk("trap_mepc", bus.mepc_o, 64'h8000_0100);
        rd(CSR_MCAUSE, v);  chk("trap_mcause", v, 64'h2);
        rd(CSR_MTVAL, v);   chk("trap_mtval", v, 64'hdead);
        rd(CSR_MSTATUS, v); chk("trap_mstatus", v, 64'h0000_000a_0000_1880);

        // mret alongside an unrelated CSR write
        bus.mret_i = 1'b1;
        csr(CSR_MSCRATCH, CSR_OP_WRITE, 64'h55);
        tick();
        bus.mret_i = 1'b0;
        rd(CSR_MSTATUS, v);  chk("mret_mstatus", v, 64'h0000_000a_0000_1888);
        rd(CSR_MSCRATCH, v); chk("mret_mscratch", v, 64'h55);

        // Vectored trap target
        csr(CSR_MTVEC, CSR_OP_WRITE, 64'h8000_0001); tick();
        rd(CSR_MTVEC, v); chk("mtvec_vectored", v, 64'h8000_0001);
        bus.trap_cause_i = 64'h8000_0000_0000_0007; #1;
        chk("tvec_interrupt", bus.trap_vector_o, 64'h8000_001C);
        bus.trap_cause_i = 64'h2; #1;
        chk("tvec_sync", bus.trap_vector_o, 64'h8000_0000);
        csr(CSR_MTVEC, CSR_OP_WRITE, 64'h8000_0003); tick();
        rd(CSR_MTVEC, v); chk("mtvec_mode3", v, 64'h8000_0000);
        csr(CSR_MEPC, CSR_OP_WRITE, 64'h1237); tick();
        chk("mepc_align", bus.mepc_o, 64'h1234);

        // Interrupt priority
        csr(CSR_MIE, CSR_OP_WRITE, 64'hFFFF_FFFF_FFFF_FFFF); tick();
        rd(CSR_MIE, v); chk("mie_warl", v, 64'h888);
        msip = 1'b1; mtip = 1'b1; meip = 1'b1; #1;
        chk1("irq_before_edge", irq_pending, 1'b0);
        tick();
        chk1("irq_pending", irq_pending, 1'b1);
        chk("irq_cause_mei", irq_cause, 64'h8000_0000_0000_000B);
        rd(CSR_MIP, v); chk("mip_all", v, 64'h888);
        meip = 1'b0; tick();
        chk("irq_cause_msi", irq_cause, 64'h8000_0000_0000_0003);
        msip = 1'b0; tick();
        chk("irq_cause_mti", irq_cause, 64'h8000_0000_0000_0007);
        csr(CSR_MSTATUS, CSR_OP_CLEAR, 64'h8); tick();
        chk1("irq_masked", irq_pending, 1'b0);
        chk("irq_cause_masked", irq_cause, 64'h0);
        mtip = 1'b0;

        // minstret: write beats increment, then inhibit freezes it
        retire = 1'b1;
        csr(CSR_MINSTRET, CSR_OP_WRITE, 64'h50); tick();
        rd(CSR_MINSTRET, v); chk("minstret_write_wins", v, 64'h50);
        tick();
        rd(CSR_MINSTRET, v); chk("minstret_inc", v, 64'h51);
        csr(CSR_MCOUNTINHIBIT, CSR_OP_WRITE, 64'h4); tick();
        rd(CSR_MINSTRET, v); chk("minstret_last_inc", v, 64'h52);
        rd(CSR_MCOUNTINHIBIT, v); chk("mcountinhibit", v, 64'h4);
        tick(); tick();
        rd(CSR_MINSTRET, v); chk("minstret_frozen", v, 64'h52);
        retire = 1'b0;

        // mcycle wrap
        csr(CSR_MCYCLE, CSR_OP_WRITE, 64'hFFFF_FFFF_FFFF_FFFF); tick();
        rd(CSR_MCYCLE, v); chk("mcycle_written", v, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        rd(CSR_MCYCLE, v); chk("mcycle_wrap", v, 64'h0);

        // hpm counters count only their own event
        hpm_event = 2'b01;
        csr(CSR_MHPMCOUNTER3, CSR_OP_WRITE, 64'd10); tick();
        rd(CSR_MHPMCOUNTER3, v); chk("hpm3_write", v, 64'd10);
        tick();
        rd(CSR_MHPMCOUNTER3, v); chk("hpm3_inc", v, 64'd11);
        rd(12'hB04, v); chk("hpm4_idle", v, 64'd0);
        hpm_event = 2'b00;

        // Reset asserted mid-cycle with an op and a trap pending
        bus.trap_valid_i = 1'b1;
        bus.trap_epc_i   = 64'h4000;
        csr(CSR_MSCRATCH, CSR_OP_WRITE, 64'h77);
        #2 rst = 1'b1;
        #1;
        chk("midrst_mepc_o", bus.mepc_o, 64'h0);
        chk("midrst_trap_vector", bus.trap_vector_o, 64'h0);
        chk1("midrst_irq_pending", irq_pending, 1'b0);
        rd(CSR_MSTATUS, v); chk("midrst_mstatus", v, 64'h0000_000a_0000_1800);
        tick();
        rst = 1'b0;
        bus.trap_valid_i = 1'b0;
        rd(CSR_MSCRATCH, v); chk("midrst_mscratch", v, 64'h0);
        chk("midrst_mepc_after", bus.mepc_o, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
